wb_arbiter: RTL and testbench

Writeback arbiter sitting directly upstream of the register file write port. It merges two result sources onto the single `regwrite`/`write_reg`/`write_data` port: the in-order pipeline writeback, which has no backpressure and has priority, and a long-latency unit (divider/multi-cycle load), which uses a valid/ready handshake. Long-latency results are buffered in a small FIFO and drain into free write slots. The block exports a busy mask for the hazard unit and a stall request to prevent starvation.

---
 rtl/wb_arbiter.sv | 153 +++++++++++++++
 tb/tb_wb_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter in front of the register file write port.
// It merges the in-order pipeline writeback, which has priority and cannot be
// back-pressured, with results from a long-latency unit (LU). The LU uses a
// valid/ready handshake. LU results wait in an in-order FIFO and drain into
// cycles where the pipeline does not write.
//
// Ports:
//   clock, reset_n           rising-edge clock, synchronous active-low reset
//   pipe_valid/rd/data       pipeline writeback (rd == 0 means no write)
//   lu_valid/ready/rd/data   long-latency result handshake (rd == 0 is dropped)
//   regwrite/write_reg/      registered register-file write port
//   write_data
//   stall_req                asks the pipeline for a bubble so the FIFO head drains
//   busy_mask                registers with a pending LU write (FIFO or output reg)
//   fifo_count               number of buffered LU results
module wb_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     pipe_valid,
    input  logic [4:0]               pipe_rd,
    input  logic [31:0]              pipe_data,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [4:0]               lu_rd,
    input  logic [31:0]              lu_data,
    output logic                     regwrite,
    output logic [4:0]               write_reg,
    output logic [31:0]              write_data,
    output logic                     stall_req,
    output logic [31:0]              busy_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [4:0]    fifo_rd_q   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;

    logic          regwrite_q, regwrite_d;
    logic [4:0]    write_reg_q, write_reg_d;
    logic [31:0]   write_data_q, write_data_d;
    // Set when the output register carries an LU-sourced write.
    logic          lu_src_q, lu_src_d;

    logic          pipe_claim;
    logic          push;
    logic          pop;

    // Readiness comes from the registered count only, so a pop in a full
    // cycle does not open the FIFO until the following cycle.
    assign lu_ready   = (count_q < FULL_CNT);
    assign stall_req  = (starve_q == STARVE_MAX);
    assign fifo_count = count_q;
    assign regwrite   = regwrite_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

    always_comb begin
        pipe_claim = pipe_valid && (pipe_rd != '0);
        push       = lu_valid && lu_ready && (lu_rd != '0);
        // Only entries already in the FIFO can pop: no enqueue-to-output bypass.
        pop        = (count_q != '0) && !pipe_claim;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if ((count_q == '0) || pop) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end else begin
            starve_d = starve_q;
        end

        regwrite_d   = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        lu_src_d     = 1'b0;
        if (pipe_claim) begin
            regwrite_d   = 1'b1;
            write_reg_d  = pipe_rd;
            write_data_d = pipe_data;
        end else if (pop) begin
            regwrite_d   = 1'b1;
            write_reg_d  = fifo_rd_q[rd_ptr_q];
            write_data_d = fifo_data_q[rd_ptr_q];
            lu_src_d     = 1'b1;
        end
    end

    // Walk the live window starting at the read pointer; slots outside it
    // hold stale data and must not contribute.
    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                busy_mask = busy_mask | (32'd1 << fifo_rd_q[rd_ptr_q + AW'(i)]);
            end
        end
        if (regwrite_q && lu_src_q) begin
            busy_mask = busy_mask | (32'd1 << write_reg_q);
        end
        busy_mask[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= lu_rd;
            fifo_data_q[wr_ptr_q] <= lu_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            lu_src_q     <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            regwrite_q   <= regwrite_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            lu_src_q     <= lu_src_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, corner-case sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        regwrite;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        stall_req;
    logic [31:0] busy_mask;
    logic [2:0]  fifo_count;

    always #5 clock = ~clock;

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .pipe_valid (pipe_valid),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .regwrite   (regwrite),
        .write_reg  (write_reg),
        .write_data (write_data),
        .stall_req  (stall_req),
        .busy_mask  (busy_mask),
        .fifo_count (fifo_count)
    );

    typedef struct {
        logic        rst_n;
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        rw;
        logic [4:0]  wreg;
        logic [31:0] wd;
        logic        rdy;
        int          cnt;
        logic [31:0] mask;
        logic        stall;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    int total = 0;
    int bad   = 0;

    // Reference model: buffered results as a queue, output port as plain state,
    // and the number of cycles the current head has been passed over.
    ent_t        mq[$];
    logic        m_rw;
    logic [4:0]  m_wreg;
    logic [31:0] m_wd;
    logic        m_from_lu;
    int          m_wait;

    function automatic stim_t mk(input logic r, input logic pv, input logic [31:0] prd,
                                 input logic [31:0] pd, input logic lv,
                                 input logic [31:0] lrd, input logic [31:0] ld);
        stim_t s;
        s.rst_n = r;
        s.pv    = pv;
        s.prd   = prd[4:0];
        s.pd    = pd;
        s.lv    = lv;
        s.lrd   = lrd[4:0];
        s.ld    = ld;
        return s;
    endfunction

    function automatic vec_t mkv(input stim_t s, input logic rw, input logic [31:0] wreg,
                                 input logic [31:0] wd, input logic rdy, input int cnt,
                                 input logic [31:0] mask, input logic stall);
        vec_t v;
        v.s     = s;
        v.rw    = rw;
        v.wreg  = wreg[4:0];
        v.wd    = wd;
        v.rdy   = rdy;
        v.cnt   = cnt;
        v.mask  = mask;
        v.stall = stall;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input stim_t s);
        ent_t e;
        bit   was_empty;
        bit   claim;
        bit   popped;
        bit   can_take;
        if (!s.rst_n) begin
            mq.delete();
            m_rw      = 1'b0;
            m_wreg    = '0;
            m_wd      = '0;
            m_from_lu = 1'b0;
            m_wait    = 0;
        end else begin
            was_empty = (mq.size() == 0);
            can_take  = (mq.size() < DEPTH);
            claim     = s.pv && (s.prd != 0);
            popped    = !was_empty && !claim;
            if (claim) begin
                m_rw = 1'b1; m_wreg = s.prd; m_wd = s.pd; m_from_lu = 1'b0;
            end else if (popped) begin
                e = mq.pop_front();
                m_rw = 1'b1; m_wreg = e.rd; m_wd = e.data; m_from_lu = 1'b1;
            end else begin
                m_rw = 1'b0; m_from_lu = 1'b0;
            end
            if (was_empty || popped) m_wait = 0;
            else if (m_wait < LIMIT) m_wait = m_wait + 1;
            if (s.lv && can_take && (s.lrd != 0)) begin
                e.rd = s.lrd; e.data = s.ld;
                mq.push_back(e);
            end
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (mq[i]) m |= 32'd1 << mq[i].rd;
        if (m_rw && m_from_lu) m |= 32'd1 << m_wreg;
        return m & ~32'd1;
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_regwrite"},  32'(regwrite), 32'(m_rw));
        check({tag, "_write_reg"}, 32'(write_reg), 32'(m_wreg));
        check({tag, "_write_dat"}, write_data, m_wd);
        check({tag, "_lu_ready"},  32'(lu_ready), 32'(mq.size() < DEPTH));
        check({tag, "_count"},     32'(fifo_count), 32'(mq.size()));
        check({tag, "_busy"},      busy_mask, model_mask());
        check({tag, "_stall"},     32'(stall_req), 32'(m_wait == LIMIT));
    endtask

    task automatic apply(input stim_t s, input string tag);
        reset_n    = s.rst_n;
        pipe_valid = s.pv;
        pipe_rd    = s.prd;
        pipe_data  = s.pd;
        lu_valid   = s.lv;
        lu_rd      = s.lrd;
        lu_data    = s.ld;
        model_step(s);
        @(posedge clock);
        #1;
        check_model(tag);
    endtask

    vec_t tbl[20];

    initial begin
        stim_t idle;
        idle = mk(1, 0, 0, 0, 0, 0, 0);

        // reset with all inputs active
        tbl[0]  = mkv(mk(0, 1, 3, 32'h11, 1, 4, 32'h22), 0, 0, 0, 1, 0, 0, 0);
        tbl[1]  = mkv(mk(0, 1, 3, 32'h11, 1, 4, 32'h22), 0, 0, 0, 1, 0, 0, 0);
        // pipeline only, then rd=0 discarded
        tbl[2]  = mkv(mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0), 1, 5, 32'hDEADBEEF, 1, 0, 0, 0);
        tbl[3]  = mkv(mk(1, 1, 0, 32'h5555, 0, 0, 0),     0, 5, 32'hDEADBEEF, 1, 0, 0, 0);
        // single LU result drains two cycles after handshake
        tbl[4]  = mkv(mk(1, 0, 0, 0, 1, 7, 32'h12345678), 0, 5, 32'hDEADBEEF, 1, 1, 32'h80, 0);
        tbl[5]  = mkv(idle, 1, 7, 32'h12345678, 1, 0, 32'h80, 0);
        tbl[6]  = mkv(idle, 0, 7, 32'h12345678, 1, 0, 0, 0);
        // fill under a busy pipeline, fifth offer refused
        tbl[7]  = mkv(mk(1, 1, 1, 32'h100, 1, 8, 32'h800),  1, 1, 32'h100, 1, 1, 32'h100, 0);
        tbl[8]  = mkv(mk(1, 1, 2, 32'h200, 1, 9, 32'h900),  1, 2, 32'h200, 1, 2, 32'h300, 0);
        tbl[9]  = mkv(mk(1, 1, 3, 32'h300, 1, 10, 32'hA00), 1, 3, 32'h300, 1, 3, 32'h700, 0);
        tbl[10] = mkv(mk(1, 1, 4, 32'h400, 1, 11, 32'hB00), 1, 4, 32'h400, 0, 4, 32'hF00, 0);
        tbl[11] = mkv(mk(1, 1, 5, 32'h500, 1, 12, 32'hC00), 1, 5, 32'h500, 0, 4, 32'hF00, 0);
        // pipeline released: pop while full does not accept the pending offer
        tbl[12] = mkv(mk(1, 0, 0, 0, 1, 12, 32'hC00), 1, 8,  32'h800, 1, 3, 32'hF00, 0);
        tbl[13] = mkv(mk(1, 0, 0, 0, 1, 12, 32'hC00), 1, 9,  32'h900, 1, 3, 32'h1E00, 0);
        tbl[14] = mkv(idle, 1, 10, 32'hA00, 1, 2, 32'h1C00, 0);
        tbl[15] = mkv(idle, 1, 11, 32'hB00, 1, 1, 32'h1800, 0);
        tbl[16] = mkv(idle, 1, 12, 32'hC00, 1, 0, 32'h1000, 0);
        tbl[17] = mkv(idle, 0, 12, 32'hC00, 1, 0, 0, 0);
        // lu_rd = 0 is accepted but never buffered or written
        tbl[18] = mkv(mk(1, 0, 0, 0, 1, 0, 32'hBAD), 0, 12, 32'hC00, 1, 0, 0, 0);
        tbl[19] = mkv(idle, 0, 12, 32'hC00, 1, 0, 0, 0);

        for (int k = 0; k < 20; k++) begin
            apply(tbl[k].s, $sformatf("vec%0d_model", k));
            check($sformatf("vec%0d_regwrite", k),  32'(regwrite),   32'(tbl[k].rw));
            check($sformatf("vec%0d_write_reg", k), 32'(write_reg),  32'(tbl[k].wreg));
            check($sformatf("vec%0d_write_dat", k), write_data,      tbl[k].wd);
            check($sformatf("vec%0d_lu_ready", k),  32'(lu_ready),   32'(tbl[k].rdy));
            check($sformatf("vec%0d_count", k),     32'(fifo_count), 32'(tbl[k].cnt));
            check($sformatf("vec%0d_busy", k),      busy_mask,       tbl[k].mask);
            check($sformatf("vec%0d_stall", k),     32'(stall_req),  32'(tbl[k].stall));
        end

        // starvation: one entry held back by a continuously busy pipeline
        apply(mk(1, 1, 1, 32'h1, 1, 20, 32'hA20), "starve_enq");
        for (int i = 1; i <= 7; i++) begin
            apply(mk(1, 1, i + 1, i, 0, 0, 0), "starve_wait");
            check("starve_not_yet", 32'(stall_req), 32'd0);
        end
        apply(mk(1, 1, 9, 32'h9, 0, 0, 0), "starve_hit");
        check("starve_asserted", 32'(stall_req), 32'd1);
        apply(mk(1, 1, 10, 32'h10, 0, 0, 0), "starve_violate");
        check("violate_stall_holds", 32'(stall_req), 32'd1);
        check("violate_pipe_wins", 32'(write_reg), 32'd10);
        apply(idle, "starve_drain");
        check("drain_stall_clear", 32'(stall_req), 32'd0);
        check("drain_write_reg", 32'(write_reg), 32'd20);
        check("drain_regwrite", 32'(regwrite), 32'd1);

        // steady enqueue+dequeue at count 2 across pointer wrap
        apply(mk(1, 1, 3, 32'h3, 1, 13, 32'hD13), "sim_fill");
        apply(mk(1, 1, 4, 32'h4, 1, 14, 32'hD14), "sim_fill");
        for (int i = 0; i < 10; i++) begin
            apply(mk(1, 0, 0, 0, 1, 15 + i, 32'hE000 + i), "sim_steady");
            check("sim_count_two", 32'(fifo_count), 32'd2);
        end
        for (int i = 0; i < 3; i++) apply(idle, "sim_drain");

        // reset with three entries buffered plus a handshake in the reset cycle
        apply(mk(1, 1, 5, 32'h5, 1, 21, 32'hF21), "rst_fill");
        apply(mk(1, 1, 6, 32'h6, 1, 22, 32'hF22), "rst_fill");
        apply(mk(1, 1, 7, 32'h7, 1, 23, 32'hF23), "rst_fill");
        check("rst_pre_count", 32'(fifo_count), 32'd3);
        apply(mk(0, 1, 8, 32'h8, 1, 24, 32'hF24), "rst_mid");
        check("rst_count_zero", 32'(fifo_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            apply(idle, "rst_after");
            check("rst_no_stale_write", 32'(regwrite), 32'd0);
            check("rst_mask_clear", busy_mask, 32'd0);
        end

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            stim_t s;
            s.rst_n = ($urandom_range(0, 99) != 0);
            s.pv    = ($urandom_range(0, 99) < 55);
            s.prd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            s.pd    = $urandom;
            s.lv    = ($urandom_range(0, 99) < 45);
            s.lrd   = 5'($urandom_range(0, 31));
            s.ld    = $urandom;
            apply(s, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
